// File: rtl/mem_if_pkg.sv
// Shared types and default widths for the cache-to-main-memory interface.
// Contents:
//   mresp_state_t : responder FSM state (idle / access in flight)
//   mem_op_t      : latched operation of the in-flight access
//   MEM_AWIDTH    : default word-address width
//   MEM_DWIDTH    : default data-word width
package mem_if_pkg;

    localparam int unsigned MEM_AWIDTH = 9;
    localparam int unsigned MEM_DWIDTH = 32;

    typedef enum logic {MR_IDLE, MR_BUSY} mresp_state_t;
    typedef enum logic {OP_RD, OP_WR} mem_op_t;

endpackage

// File: rtl/main_mem_array.sv
// Single-port word-addressed backing store.
// Synchronous read and synchronous write, no reset; contents survive a system reset.
// Read-during-write returns the old word.
// Ports:
//   clock : clock
//   addr  : word address
//   din   : write data
//   we    : write enable
//   dout  : registered read data for addr sampled at the previous edge
module main_mem_array
    import mem_if_pkg::*;
#(
    parameter int unsigned AWIDTH = MEM_AWIDTH,
    parameter int unsigned DWIDTH = MEM_DWIDTH
) (
    input  logic              clock,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] din,
    input  logic              we,
    output logic [DWIDTH-1:0] dout
);

    localparam int unsigned Depth = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem_q [Depth];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout <= mem_q[addr];
    end

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory slave answering single-word requests from the cache controller.
// A request accepted in IDLE keeps the responder BUSY for LATENCY edges; on the last
// BUSY edge a read loads data_mem_in from the array, or a write commits to the array.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   addr_mem       : request word address
//   rd_mem, wr_mem : one-cycle request pulses (write wins if both)
//   data_mem_out   : write data, valid with wr_mem
//   data_mem_in    : read data, held until the next read completes
//   ready_mem      : idle and no request presented this cycle
//   rd_count       : accepted reads, saturating
//   wr_count       : accepted writes, saturating
//   proto_err      : sticky flag for simultaneous rd/wr or request while busy
module main_mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned AWIDTH  = MEM_AWIDTH,
    parameter int unsigned DWIDTH  = MEM_DWIDTH,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned CWIDTH  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [AWIDTH-1:0] addr_mem,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic [DWIDTH-1:0] data_mem_out,
    output logic [DWIDTH-1:0] data_mem_in,
    output logic              ready_mem,
    output logic [CWIDTH-1:0] rd_count,
    output logic [CWIDTH-1:0] wr_count,
    output logic              proto_err
);

    // LATENCY is at most 15, so four bits hold the countdown.
    localparam int unsigned BW = 4;
    localparam logic [BW-1:0] BusyLoad = BW'(LATENCY - 1);

    mresp_state_t      state_q, state_d;
    logic [BW-1:0]     busy_cnt_q, busy_cnt_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    mem_op_t           op_q, op_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic [CWIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [CWIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic              err_q, err_d;

    logic              req;
    logic              last_edge;
    logic              arr_we;
    logic [DWIDTH-1:0] arr_dout;

    assign req       = rd_mem | wr_mem;
    assign last_edge = (state_q == MR_BUSY) && (busy_cnt_q == '0);
    // Write is gated by state, so a reset mid-access discards the pending write.
    assign arr_we    = last_edge && (op_q == OP_WR);

    // Array address comes from the latch, so dout is valid from the first BUSY edge.
    main_mem_array #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_array (
        .clock (clock),
        .addr  (addr_q),
        .din   (wdata_q),
        .we    (arr_we),
        .dout  (arr_dout)
    );

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        addr_d     = addr_q;
        op_d       = op_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;

        case (state_q)
            MR_IDLE: begin
                if (req) begin
                    state_d    = MR_BUSY;
                    busy_cnt_d = BusyLoad;
                    addr_d     = addr_mem;
                    if (wr_mem) begin
                        op_d    = OP_WR;
                        wdata_d = data_mem_out;
                        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CWIDTH'(1);
                        if (rd_mem) err_d = 1'b1;
                    end else begin
                        op_d = OP_RD;
                        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CWIDTH'(1);
                    end
                end
            end
            MR_BUSY: begin
                if (req) err_d = 1'b1;
                if (busy_cnt_q == '0) begin
                    state_d = MR_IDLE;
                    if (op_q == OP_RD) rdata_d = arr_dout;
                end else begin
                    busy_cnt_d = busy_cnt_q - BW'(1);
                end
            end
            default: state_d = MR_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= MR_IDLE;
            busy_cnt_q <= '0;
            addr_q     <= '0;
            op_q       <= OP_RD;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            err_q      <= err_d;
        end
    end

    // Drops combinationally with the request so the requester never sees a stale ready.
    assign ready_mem   = (state_q == MR_IDLE) & ~rd_mem & ~wr_mem;
    assign data_mem_in = rdata_q;
    assign rd_count    = rd_cnt_q;
    assign wr_count    = wr_cnt_q;
    assign proto_err   = err_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder: the stimulus thread pushes the expected
// completion state for each access, a monitor pops and compares when ready_mem rises.
module tb_main_mem_responder;

    localparam int unsigned LAT = 4;

    typedef struct {
        logic [31:0] data;
        logic [15:0] rdc;
        logic [15:0] wrc;
        logic        err;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [8:0]  addr_mem;
    logic        rd_mem;
    logic        wr_mem;
    logic [31:0] data_mem_out;
    logic [31:0] data_mem_in;
    logic        ready_mem;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    exp_t        sb_q[$];
    logic [31:0] mem_m[int];
    logic [31:0] last_m = 32'h0;
    logic [15:0] rd_m   = 16'h0;
    logic [15:0] wr_m   = 16'h0;
    logic        err_m  = 1'b0;

    main_mem_responder #(
        .AWIDTH  (9),
        .DWIDTH  (32),
        .LATENCY (LAT),
        .CWIDTH  (16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .addr_mem     (addr_mem),
        .rd_mem       (rd_mem),
        .wr_mem       (wr_mem),
        .data_mem_out (data_mem_out),
        .data_mem_in  (data_mem_in),
        .ready_mem    (ready_mem),
        .rd_count     (rd_count),
        .wr_count     (wr_count),
        .proto_err    (proto_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clock);
        while (!ready_mem && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!ready_mem) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=%0b required=1", ready_mem);
        end
    endtask

    // Issue one request; inject pulses an extra rd_mem while the access is busy.
    task automatic issue(input logic rd, input logic wr, input logic [8:0] a,
                         input logic [31:0] d, input bit inject);
        exp_t e;
        wait_ready();
        if (wr) begin
            mem_m[int'(a)] = d;
            if (wr_m != 16'hFFFF) wr_m++;
            if (rd) err_m = 1'b1;
        end else begin
            if (rd_m != 16'hFFFF) rd_m++;
            last_m = mem_m.exists(int'(a)) ? mem_m[int'(a)] : 32'h0;
        end
        if (inject) err_m = 1'b1;
        e.data = last_m;
        e.rdc  = rd_m;
        e.wrc  = wr_m;
        e.err  = err_m;
        sb_q.push_back(e);
        rd_mem = rd;
        wr_mem = wr;
        addr_mem = a;
        data_mem_out = d;
        @(negedge clock);
        rd_mem = 1'b0;
        wr_mem = 1'b0;
        if (inject) begin
            @(negedge clock);
            rd_mem = 1'b1;
            addr_mem = a ^ 9'h001;
            @(negedge clock);
            rd_mem = 1'b0;
        end
    endtask

    // Monitor: a rising ready_mem after a low run marks one completed access.
    initial begin : monitor
        logic prev;
        int   low_run;
        exp_t e;
        prev = 1'b1;
        low_run = 0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset_n) begin
                prev = 1'b1;
                low_run = 0;
            end else if (!ready_mem) begin
                low_run++;
                prev = 1'b0;
            end else begin
                if (!prev) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion actual=1 required=0");
                    end else begin
                        e = sb_q.pop_front();
                        check("data_mem_in", data_mem_in, e.data);
                        check("rd_count", {16'h0, rd_count}, {16'h0, e.rdc});
                        check("wr_count", {16'h0, wr_count}, {16'h0, e.wrc});
                        check("proto_err", {31'h0, proto_err}, {31'h0, e.err});
                        check("busy_cycles", low_run, LAT);
                    end
                end
                prev = 1'b1;
                low_run = 0;
            end
        end
    end

    initial begin : stim
        int n;
        reset_n = 1'b0;
        rd_mem = 1'b0;
        wr_mem = 1'b0;
        addr_mem = 9'h0;
        data_mem_out = 32'h0;
        #3;
        check("rst_ready", {31'h0, ready_mem}, 32'h1);
        check("rst_data", data_mem_in, 32'h0);
        check("rst_rd_count", {16'h0, rd_count}, 32'h0);
        check("rst_wr_count", {16'h0, wr_count}, 32'h0);
        check("rst_proto_err", {31'h0, proto_err}, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Write then read of the same address.
        issue(1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 1'b0);
        issue(1'b1, 1'b0, 9'h005, 32'h0, 1'b0);

        // Preload, then back-to-back reads at the address extremes.
        issue(1'b0, 1'b1, 9'h000, 32'h00000001, 1'b0);
        issue(1'b0, 1'b1, 9'h1FF, 32'h00000002, 1'b0);
        issue(1'b1, 1'b0, 9'h000, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 9'h1FF, 32'h0, 1'b0);

        // Simultaneous rd/wr: write wins and the error flag sets.
        issue(1'b1, 1'b1, 9'h010, 32'hA5A5A5A5, 1'b0);
        issue(1'b1, 1'b0, 9'h010, 32'h0, 1'b0);

        // Read pulse during BUSY is ignored.
        issue(1'b1, 1'b0, 9'h005, 32'h0, 1'b1);

        // Reset two cycles into a write: the write is discarded.
        issue(1'b0, 1'b1, 9'h020, 32'h00000000, 1'b0);
        wait_ready();
        addr_mem = 9'h020;
        data_mem_out = 32'h12345678;
        wr_mem = 1'b1;
        @(negedge clock);
        wr_mem = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_ready", {31'h0, ready_mem}, 32'h1);
        check("abort_data", data_mem_in, 32'h0);
        check("abort_rd_count", {16'h0, rd_count}, 32'h0);
        check("abort_wr_count", {16'h0, wr_count}, 32'h0);
        check("abort_proto_err", {31'h0, proto_err}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        rd_m = 16'h0;
        wr_m = 16'h0;
        err_m = 1'b0;
        last_m = 32'h0;
        issue(1'b1, 1'b0, 9'h020, 32'h0, 1'b0);

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
        end
        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
